dac_sample_sequencer: RTL
=========================

Name: dac_sample_sequencer

Overview:
- Paces 10-bit sample codes from the core into the avsddac D input at a programmable update rate.
- Buffers samples in a small FIFO using a valid/ready handshake.
- Drives the DAC enable and holds the last code on underrun.
- Sits between the RVMYTH-side sample writer and the avsddac macro. It is the only driver of D/EN.

Parameters:
- DW, 10, sample/DAC code width.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- RESET_CODE, 10'h000, dac_d value after reset.
- SLEW_STEP, 16, maximum per-tick code change; used only with DAC_SLEW_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; 1 = run the sequencer, 0 = stop.
- div_cfg  in  16  update period minus 1, in clk cycles.
- s_valid  in  1  sample offered.
- s_data  in  DW  sample code.
- s_ready  out  1  FIFO can accept; equals !full.
- dac_d  out  DW  registered code to avsddac D.
- dac_en  out  1  registered enable to avsddac EN.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.
- underrun  out  1  sticky: a tick found no sample.
- clr_underrun  in  1  clears underrun.
- busy  out  1  state == RUN.

Behaviour:
- Reset values:
  - dac_d = RESET_CODE; dac_en = 0; underrun = 0; fifo_level = 0.
  - s_ready = 1; busy = 0; state = IDLE; divider count = 0; FIFO pointers = 0.
- Push: s_valid & s_ready at a rising edge writes s_data. No push while full, even if a pop occurs in the same cycle. Push into the FIFO is allowed in every state.
- States:
  - IDLE: dac_en = 0; count held at 0; dac_d holds its value.
  - IDLE -> RUN on enable = 1. dac_en = 1 from the next cycle.
  - RUN: count increments each cycle. Tick when count >= div_cfg; count returns to 0 on a tick. The >= compare makes a div_cfg decrease take effect without a 65536-cycle wrap.
  - div_cfg = 0 -> tick every cycle; div_cfg = N -> one tick per N+1 cycles.
  - First tick occurs div_cfg+1 cycles after entering RUN.
  - RUN -> IDLE when enable = 0. Takes effect the next edge; a tick in that same cycle is still processed. The FIFO is not flushed; dac_d retains its last code.
- Tick with FIFO non-empty: pop the head. dac_d = head at that edge, so it is visible the cycle after the tick.
- Tick with FIFO empty: dac_d unchanged; underrun <= 1.
- Push to an empty FIFO in the tick cycle does not satisfy that tick; underrun is set.
- clr_underrun clears underrun. If clr_underrun and a new underrun occur in the same cycle, set wins.
- fifo_level updates the edge after each push/pop. Simultaneous push and pop leaves the level unchanged.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), and FIFO contents are discarded.

Optional Feature:
- Macro: DAC_SLEW_EN.
- Defined:
  - A pop loads an internal target register rather than dac_d.
  - On each tick, dac_d moves toward the target by min(|target - dac_d|, SLEW_STEP), with no overshoot.
  - The next pop happens only on a tick where dac_d already equals the target.
  - A tick where dac_d == target and the FIFO is empty sets underrun. Ticks still slewing do not.
  - The target resets to RESET_CODE.
- Undefined: a pop writes dac_d directly, as described above. No target register is built.

Test Plan:
1. Reset, then push 10'h3FA..10'h3FF (6 samples, DEPTH=4) with s_valid held high:
   - s_ready drops after 4 pushes.
   - div_cfg = 9, enable = 1.
   - dac_d steps 3FA, 3FB, ... 3FF, one step every 10 cycles; all 6 sample codes are eventually accepted.
   - dac_en = 1 throughout.
2. div_cfg = 0, FIFO pre-filled with 4 codes, enable = 1:
   - dac_d changes on 4 consecutive cycles.
   - The 5th tick sets underrun and dac_d holds the 4th code.
   - clr_underrun pulse -> underrun = 0.
3. Push and pop in the same cycle at level 2:
   - fifo_level stays 2.
   - Push while full with a simultaneous pop -> s_valid is not accepted (s_ready = 0).
4. Drop enable mid-run after 2 of 4 codes:
   - Back in IDLE, dac_en = 0 and dac_d holds the 2nd code.
   - Re-enable -> the 3rd code appears div_cfg+1 cycles later.
5. Assert reset mid-run with the FIFO at 3:
   - Outputs go to their reset values without waiting for a clk edge.
   - fifo_level = 0, underrun = 0, dac_d = RESET_CODE.
6. DAC_SLEW_EN, SLEW_STEP = 16, dac_d = 0, push 10'h030 then 10'h005, div_cfg = 0:
   - dac_d follows 0x010, 0x020, 0x030, 0x020, 0x010, 0x005.
   - No underrun until the tick after reaching 0x005.

Source files
------------

// File: rtl/dac_sample_sequencer.sv
// Paces DW-bit codes from a small FIFO into the avsddac D/EN inputs.
// Optional DAC_SLEW_EN: rate-limits dac_d toward each popped code.
module dac_sample_sequencer #(
    parameter int             DW         = 10,
    parameter int             DEPTH      = 4,
    parameter logic [DW-1:0]  RESET_CODE = '0,
    parameter int             SLEW_STEP  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [15:0]              div_cfg,
    input  logic                     s_valid,
    input  logic [DW-1:0]            s_data,
    output logic                     s_ready,
    output logic [DW-1:0]            dac_d,
    output logic                     dac_en,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2, at least 2");
    end
    if (SLEW_STEP < 1) begin : g_slew_chk
        $error("SLEW_STEP must be at least 1");
    end

    typedef enum logic {IDLE, RUN} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [DW-1:0]   dac_q, dac_d_n;
    logic            en_q, en_d;
    logic            und_q, und_d;
    logic [DW-1:0]   mem [DEPTH];

    logic full, empty, push, pop, tick, und_set;
    logic [DW-1:0] head;

`ifdef DAC_SLEW_EN
    localparam logic [DW-1:0] STEP = DW'(SLEW_STEP);
    logic [DW-1:0] tgt_q, tgt_d, diff;
`endif

    assign full       = (lvl_q == LW'(DEPTH));
    assign empty      = (lvl_q == '0);
    assign push       = s_valid & ~full;
    assign head       = mem[rd_q];

    assign s_ready    = ~full;
    assign dac_d      = dac_q;
    assign dac_en     = en_q;
    assign fifo_level = lvl_q;
    assign underrun   = und_q;
    assign busy       = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dac_d_n = dac_q;
        tick    = 1'b0;
        pop     = 1'b0;
        und_set = 1'b0;
`ifdef DAC_SLEW_EN
        tgt_d   = tgt_q;
        diff    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) state_d = RUN;
            end
            RUN: begin
                // >= lets a lowered div_cfg take effect without wrapping
                tick  = (cnt_q >= div_cfg);
                cnt_d = tick ? '0 : cnt_q + 16'd1;
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DAC_SLEW_EN
        if (tick) begin
            if (dac_q == tgt_q) begin
                if (!empty) begin
                    pop   = 1'b1;
                    tgt_d = head;
                end else begin
                    und_set = 1'b1;
                end
            end else if (tgt_q > dac_q) begin
                diff    = tgt_q - dac_q;
                dac_d_n = dac_q + ((diff > STEP) ? STEP : diff);
            end else begin
                diff    = dac_q - tgt_q;
                dac_d_n = dac_q - ((diff > STEP) ? STEP : diff);
            end
        end
`else
        if (tick) begin
            if (!empty) begin
                pop     = 1'b1;
                dac_d_n = head;
            end else begin
                und_set = 1'b1;
            end
        end
`endif

        en_d  = (state_d == RUN);
        und_d = und_set ? 1'b1 : (clr_underrun ? 1'b0 : und_q);
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        unique case ({push, pop})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            dac_q   <= RESET_CODE;
            en_q    <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            dac_q   <= dac_d_n;
            en_q    <= en_d;
            und_q   <= und_d;
        end
    end

`ifdef DAC_SLEW_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tgt_q <= RESET_CODE;
        else       tgt_q <= tgt_d;
    end
`endif

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= s_data;
    end

endmodule
